rc_add_sub_seq: RTL
===================

Name: rc_add_sub_seq

Overview:
Multi-cycle, parametrised successor to the 32-bit ripple-carry adder/subtractor. It processes a WIDTH-bit add or subtract SLICE bits per clock, rippling the carry through a registered carry flop between slices. This trades latency for a short combinational path. It sits beside the ALU datapath for wide (64-bit and up) or area-constrained arithmetic and reports carry, signed overflow and zero flags with a start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
SLICE, 8, bits added per clock; 1 <= SLICE <= WIDTH.
(derived) NSLICE = WIDTH/SLICE, the number of compute cycles.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  request a new operation; sampled only when BUSY=0.
A  input  WIDTH  operand A; sampled on the accepting edge.
B  input  WIDTH  operand B; sampled on the accepting edge.
SnA  input  1  0 = add (A+B), 1 = subtract (A-B); sampled on the accepting edge.
Y  output  WIDTH  result register.
CO  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned).
OV  output  1  two's-complement signed overflow.
ZERO  output  1  1 when Y == 0.
BUSY  output  1  high while an operation is in progress.
DONE  output  1  one-cycle pulse; Y and all flags are valid and new.

Behaviour:
- Reset: when RST=1 at an edge, state goes to IDLE and Y=0, CO=0, OV=0, ZERO=0, BUSY=0, DONE=0. Internal operand and carry registers are cleared. RST overrides START at the same edge.
- States:
  - IDLE: on an edge with START=1, latch A, B^{WIDTH{SnA}} and SnA. Set carry=SnA and slice index k=0. Go to RUN with BUSY=1.
  - RUN: at each edge, add slice k of A, slice k of the inverted B and the carry. Write the slice sum into the internal accumulator and store the slice carry-out in the carry flop. Then k = k+1.
  - On the edge processing k = NSLICE-1: load Y from the accumulator, then set CO = final carry and OV = (A[msb] == Bx[msb]) & (sum[msb] != A[msb]). Set ZERO = (full result == 0), DONE=1, BUSY=0 and return to IDLE.
- Latency: START accepted at edge e0; DONE is high for the one cycle following edge e0+NSLICE. With SLICE=WIDTH, NSLICE=1.
- Throughput: START may be held or asserted in the DONE cycle and is accepted on the next edge. Back-to-back period is NSLICE+1 cycles.
- START while BUSY=1 is ignored: no queuing, and the in-flight operands are unaffected. Input changes during RUN have no effect.
- Y, CO, OV and ZERO are written only at completion. They hold their values through IDLE and through the next RUN until that operation completes. No partial results ever appear on Y.
- DONE is exactly one cycle wide and is never asserted without a preceding accepted START.
- RST during RUN aborts the operation: no DONE, and outputs return to their reset values.
- The carry chain is exact across slice boundaries. Results must equal the combinational (A + (B^SnA) + SnA) mod 2^WIDTH, with CO as bit WIDTH, for all WIDTH/SLICE combinations.
- WIDTH % SLICE != 0 is a parameter error and is flagged at elaboration.

Test Plan:
1. WIDTH=32, SLICE=8: A=0x000000FF, B=0x00000001, SnA=0, START -> DONE 4 cycles after the accepting edge; Y=0x00000100, CO=0, OV=0, ZERO=0, BUSY high for exactly 4 cycles.
2. A=0xFFFFFFFF, B=0x00000001, add -> Y=0x00000000, CO=1, OV=0, ZERO=1 (carry crosses all slices). Repeat with SLICE=1 (DONE after 32 cycles) and SLICE=32 (DONE after 1 cycle) -> identical results.
3. Subtract: A=5, B=7 -> Y=0xFFFFFFFE, CO=0, OV=0. Then A=7, B=5 -> Y=0x00000002, CO=1, OV=0. Then A=B=0x12345678 -> Y=0, CO=1, ZERO=1.
4. Overflow: A=0x7FFFFFFF + B=0x00000001 -> Y=0x80000000, OV=1, CO=0. Then A=0x80000000 - B=0x00000001 -> Y=0x7FFFFFFF, OV=1, CO=1.
5. Start A=3, B=4, add; pulse START with A=100, B=100 in run cycle 2 -> second request ignored, Y=0x00000007. Next, start a new op and assert RST in run cycle 2 -> BUSY=0, no DONE, Y=0; a following A=1, B=1 add completes with Y=2.
6. Back-to-back: hold START high with changing operands each op -> ops accepted every 5 cycles (SLICE=8). Each DONE carries the matching result, and Y is stable between DONE pulses.

Source files
------------

// File: rtl/rc_add_sub_seq.sv
// rc_add_sub_seq: multi-cycle slice-serial adder/subtractor.
// One SLICE-bit chunk per clock, carry held in a flop between chunks.
module rc_add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SnA,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  if ((SLICE < 1) || (SLICE > WIDTH) ||
      ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("rc_add_sub_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sum_ext;
  logic [WIDTH-1:0] acc_nx;

  // Pick slice k of both operands, add with the stored carry,
  // and merge the slice sum into the accumulator.
  always_comb begin
    a_sl   = '0;
    b_sl   = '0;
    acc_nx = acc_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = bx_q[i*SLICE +: SLICE];
      end
    end
    sum_ext = {1'b0, a_sl} + {1'b0, b_sl} +
              {{SLICE{1'b0}}, carry_q};
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        acc_nx[i*SLICE +: SLICE] = sum_ext[SLICE-1:0];
      end
    end
  end

  // Sequencer: accept in IDLE, step slices in RUN, publish at the end.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    k_d     = k_q;
    y_d     = y_q;
    co_d    = co_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          bx_d    = B ^ {WIDTH{SnA}};
          acc_d   = '0;
          carry_d = SnA;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_nx;
        carry_d = sum_ext[SLICE];
        k_d     = k_q + 1'b1;
        if (k_q == KLAST) begin
          y_d     = acc_nx;
          co_d    = sum_ext[SLICE];
          ov_d    = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &
                    (acc_nx[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (acc_nx == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          k_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over any request on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign CO   = co_q;
  assign OV   = ov_q;
  assign ZERO = zero_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
